// File: rtl/maxnet_loader.sv
// Stream loader for the MaxNet datapath: fills the X and W register banks from a valid/ready word stream.
// Optional macro MAXNET_LOADER_GEN_WEIGHTS_EN: load only X and generate the W bank from DIAG_VAL/OFF_VAL.
module maxnet_loader #(
  parameter int                 WIDTH    = 32,
  parameter int                 N        = 4,
  parameter logic [WIDTH-1:0]   DIAG_VAL = 32'h3F800000,
  parameter logic [WIDTH-1:0]   OFF_VAL  = 32'hBE000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N*WIDTH-1:0]     x_bus,
  output logic [N*N*WIDTH-1:0]   w_bus,
  output logic [4:0]             load_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam int XB = $clog2(N);
  localparam int WB = $clog2(N*N);
  localparam logic [4:0] CNT_LAST_X = 5'(N - 1);
  localparam logic [4:0] CNT_LAST_W = 5'(N + N*N - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD_X, ST_LOAD_W, ST_DONE} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  x_q [N];
  logic [WIDTH-1:0]  w_q [N*N];
  logic [4:0]        load_cnt_q;
  logic [4:0]        load_cnt_d;
  logic              in_ready_q;
  logic              busy_q;
  logic              done_q;
  logic [XB-1:0]     x_idx_s;
  logic [WB-1:0]     w_idx_s;

  assign load_cnt_d = load_cnt_q + 5'd1;
  assign x_idx_s    = XB'(load_cnt_q);
  assign w_idx_s    = WB'(load_cnt_q - 5'(N));

`ifndef MAXNET_LOADER_GEN_WEIGHTS_EN
  logic unused_gen_s;
  assign unused_gen_s = ^{DIAG_VAL, OFF_VAL};
`endif

  // Sequencer, bank writes and handshake/status outputs share one registered block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= 5'd0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int k = 0; k < N; k++) x_q[k] <= '0;
      for (int k = 0; k < N*N; k++) w_q[k] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_LOAD_X;
            load_cnt_q <= 5'd0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_LOAD_X: begin
          if (in_valid) begin
            x_q[x_idx_s] <= in_data;
            load_cnt_q   <= load_cnt_d;
            if (load_cnt_q == CNT_LAST_X) begin
`ifdef MAXNET_LOADER_GEN_WEIGHTS_EN
              state_q    <= ST_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                  w_q[i*N+j] <= (i == j) ? DIAG_VAL : OFF_VAL;
                end
              end
`else
              state_q <= ST_LOAD_W;
`endif
            end
          end
        end
        ST_LOAD_W: begin
          if (in_valid) begin
            w_q[w_idx_s] <= in_data;
            load_cnt_q   <= load_cnt_d;
            if (load_cnt_q == CNT_LAST_W) begin
              state_q    <= ST_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Restart keeps the old bank contents; each word is overwritten as it arrives.
          if (start) begin
            state_q    <= ST_LOAD_X;
            load_cnt_q <= 5'd0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          load_cnt_q <= 5'd0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_x_bus
    assign x_bus[k*WIDTH +: WIDTH] = x_q[k];
  end

  for (genvar k = 0; k < N*N; k++) begin : g_w_bus
    assign w_bus[k*WIDTH +: WIDTH] = w_q[k];
  end

  assign in_ready = in_ready_q;
  assign load_cnt = load_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_maxnet_loader.sv
// Directed self-checking bench for maxnet_loader; expected banks are rebuilt from the stream base value.
module tb_maxnet_loader;

  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [WIDTH-1:0]      in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*WIDTH-1:0]    x_bus;
  logic [N*N*WIDTH-1:0]  w_bus;
  logic [4:0]            load_cnt;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;

  maxnet_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_bus    (x_bus),
    .w_bus    (w_bus),
    .load_cnt (load_cnt),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*WIDTH-1:0] exp_x(input logic [31:0] base);
    logic [N*WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*WIDTH +: WIDTH] = base + 32'(k);
    return v;
  endfunction

  function automatic logic [N*N*WIDTH-1:0] exp_w(input logic [31:0] base);
    logic [N*N*WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < N*N; k++) v[k*WIDTH +: WIDTH] = base + 32'(N + k);
    return v;
  endfunction

  task automatic send_stream(input logic [31:0] base, input int toggle);
    for (int k = 0; k < N + N*N; k++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(k);
      tick();
      chk("stream_done", {511'd0, done}, {511'd0, (k == N + N*N - 1)});
      if (toggle != 0) begin
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_final(input string tag, input logic [31:0] base);
    chk({tag, "_x"}, 512'(x_bus), 512'(exp_x(base)));
    chk({tag, "_w"}, 512'(w_bus), 512'(exp_w(base)));
    chk({tag, "_cnt"}, 512'(load_cnt), 512'(5'd20));
    chk({tag, "_done"}, 512'(done), 512'(1'b1));
    chk({tag, "_ready"}, 512'(in_ready), 512'(1'b0));
    chk({tag, "_busy"}, 512'(busy), 512'(1'b0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 512'(in_ready), 512'(1'b0));
    chk("rst_busy", 512'(busy), 512'(1'b0));
    chk("rst_done", 512'(done), 512'(1'b0));
    chk("rst_cnt", 512'(load_cnt), 512'(5'd0));
    chk("rst_x", 512'(x_bus), 512'd0);
    chk("rst_w", 512'(w_bus), 512'd0);

`ifdef MAXNET_LOADER_GEN_WEIGHTS_EN
    begin
      logic [N*N*WIDTH-1:0] gw;
      logic [N*WIDTH-1:0]   gx;
      logic [31:0]          xs [4];
      xs[0] = 32'd7; xs[1] = 32'd3; xs[2] = 32'd9; xs[3] = 32'd1;
      for (int i = 0; i < N; i++) begin
        gx[i*WIDTH +: WIDTH] = xs[i];
        for (int j = 0; j < N; j++)
          gw[(i*N+j)*WIDTH +: WIDTH] = (i == j) ? 32'h3F80_0000 : 32'hBE00_0000;
      end
      start = 1'b1; tick(); start = 1'b0;
      chk("gen_ready", 512'(in_ready), 512'(1'b1));
      for (int k = 0; k < N; k++) begin
        in_valid = 1'b1; in_data = xs[k];
        tick();
        chk("gen_done", 512'(done), 512'(k == N - 1));
      end
      in_valid = 1'b0;
      chk("gen_x", 512'(x_bus), 512'(gx));
      chk("gen_w", 512'(w_bus), 512'(gw));
      chk("gen_cnt", 512'(load_cnt), 512'(5'd4));
      chk("gen_ready_end", 512'(in_ready), 512'(1'b0));
      chk("gen_busy_end", 512'(busy), 512'(1'b0));
    end
`else
    // Back-to-back load of 1..20, with a partial-progress look after the X words.
    start = 1'b1; tick(); start = 1'b0;
    chk("arm_ready", 512'(in_ready), 512'(1'b1));
    chk("arm_busy", 512'(busy), 512'(1'b1));
    chk("arm_cnt", 512'(load_cnt), 512'(5'd0));
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1; in_data = 32'(k + 1); tick();
    end
    in_valid = 1'b0;
    chk("mid_x", 512'(x_bus), 512'(exp_x(32'd1)));
    chk("mid_w", 512'(w_bus), 512'd0);
    chk("mid_cnt", 512'(load_cnt), 512'(5'd4));
    for (int k = N; k < N + N*N; k++) begin
      in_valid = 1'b1; in_data = 32'(k + 1); tick();
      chk("b2b_done", 512'(done), 512'(k == N + N*N - 1));
    end
    in_valid = 1'b0;
    check_final("b2b", 32'd1);

    // Words offered in DONE are ignored.
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; tick(); tick(); in_valid = 1'b0;
    check_final("done_ignore", 32'd1);

    // Toggled in_valid with garbage on the idle cycles, from a clean reset.
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    send_stream(32'd1, 1);
    check_final("toggle", 32'd1);

    // Reset mid-sequence after 7 words discards everything.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; in_data = 32'h50 + 32'(k); tick();
    end
    chk("pre_rst_cnt", 512'(load_cnt), 512'(5'd7));
    rst = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0;
    chk("mrst_x", 512'(x_bus), 512'd0);
    chk("mrst_w", 512'(w_bus), 512'd0);
    chk("mrst_cnt", 512'(load_cnt), 512'(5'd0));
    chk("mrst_ready", 512'(in_ready), 512'(1'b0));
    chk("mrst_busy", 512'(busy), 512'(1'b0));

    // Words offered in IDLE are ignored.
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; tick(); tick();
    chk("idle_x", 512'(x_bus), 512'd0);
    chk("idle_cnt", 512'(load_cnt), 512'(5'd0));

    // start together with in_valid: only the state change happens.
    start = 1'b1; in_data = 32'd1; tick(); start = 1'b0; in_valid = 1'b0;
    chk("sv_cnt", 512'(load_cnt), 512'(5'd0));
    chk("sv_x", 512'(x_bus), 512'd0);
    send_stream(32'd1, 0);
    check_final("reload", 32'd1);

    // start pulsed in LOAD_W at load_cnt=10 is ignored.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < N + N*N; k++) begin
      if (k == 10) chk("lw_cnt10", 512'(load_cnt), 512'(5'd10));
      start    = (k == 10);
      in_valid = 1'b1; in_data = 32'h30 + 32'(k); tick();
    end
    start = 1'b0; in_valid = 1'b0;
    check_final("busy_start", 32'h30);

    // Restart from DONE: done drops, banks are kept until overwritten.
    start = 1'b1; tick(); start = 1'b0;
    chk("rs_done", 512'(done), 512'(1'b0));
    chk("rs_busy", 512'(busy), 512'(1'b1));
    chk("rs_cnt", 512'(load_cnt), 512'(5'd0));
    chk("rs_x_kept", 512'(x_bus), 512'(exp_x(32'h30)));
    chk("rs_w_kept", 512'(w_bus), 512'(exp_w(32'h30)));
    send_stream(32'hA0, 0);
    check_final("second", 32'hA0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
